pipelined_adder: RTL and testbench

//  - Parametrised, pipelined WIDTH-bit ripple-carry adder; successor to the single-bit combinational adder cells.
//  - Operands are split into STAGES equal chunks; one chunk is added per pipeline stage, and the carry is registered between stages.
//  - A valid/ready handshake on both sides; sits between operand-producing logic and a result consumer in the ADDERS datapath.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/pipelined_adder_if.sv | 44 ++++
 rtl/adder_chunk.sv | 32 +++
 rtl/pipelined_adder.sv | 115 +++++++++++
 tb/tb_pipelined_adder.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg
// Shared definitions for the pipelined adder slice.
//   chunk_w      : width of the slice of the operands handled by one stage.
//   params_legal : legality check for a WIDTH/STAGES pair (WIDTH must split evenly).
//   full_add     : one full-adder cell, returns {carry, sum}.
// Used by pipelined_adder and adder_chunk via import adder_pkg::*.
package adder_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit params_legal(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
  endfunction

  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if
// Operand/result handshake bundle for pipelined_adder.
//   a_in, b_in, carry_in, valid_in : operand set from the producer
//   ready_out                      : adder can take an operand set this cycle
//   sum_out, carry_out, valid_out  : registered result towards the consumer
//   ready_in                       : consumer takes the result this cycle
//   sub_in                         : subtract request, only with ADDER_SUBTRACT_EN
// Modports: master = producer/consumer environment, slave = the adder itself.
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             valid_out;
  logic             ready_in;
`ifdef ADDER_SUBTRACT_EN
  logic             sub_in;

  modport master (
    output a_in, b_in, carry_in, sub_in, valid_in, ready_in,
    input  ready_out, sum_out, carry_out, valid_out
  );

  modport slave (
    input  a_in, b_in, carry_in, sub_in, valid_in, ready_in,
    output ready_out, sum_out, carry_out, valid_out
  );
`else
  modport master (
    output a_in, b_in, carry_in, valid_in, ready_in,
    input  ready_out, sum_out, carry_out, valid_out
  );

  modport slave (
    input  a_in, b_in, carry_in, valid_in, ready_in,
    output ready_out, sum_out, carry_out, valid_out
  );
`endif
endinterface

// File: rtl/adder_chunk.sv
// adder_chunk
// Combinational WIDTH-bit ripple-carry adder made of a chain of full-adder cells.
//   a_in, b_in : chunk operands
//   carry_in   : carry into the lowest bit
//   sum_out    : chunk sum
//   carry_out  : carry out of the highest bit
module adder_chunk
  import adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  logic ripple;

  // The carry is walked through a procedural variable rather than a carry
  // vector so the chain does not form a combinational self-loop on one net.
  always_comb begin
    ripple  = carry_in;
    sum_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {ripple, sum_out[i]} = full_add(a_in[i], b_in[i], ripple);
    end
    carry_out = ripple;
  end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder
// WIDTH-bit adder split into STAGES equal chunks; each pipeline stage adds one
// chunk and registers its carry for the next stage. Valid/ready on both sides
// with a global stall: the whole pipe advances only when the output slot is
// empty or being taken.
//   clk_in   : clock, rising edge
//   rst_n_in : synchronous active-low reset, clears every stage
//   bus      : pipelined_adder_if.slave (operands in, result out, handshakes)
// Optional feature macro: ADDER_SUBTRACT_EN adds bus.sub_in, turning the
// operation into a_in - b_in (carry_out=1 means no borrow).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  pipelined_adder_if.slave   bus
);

  localparam int C = chunk_w(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be >= 1 and divisible by STAGES >= 1");
  end

  // One pipeline slot. Full-width a/b are carried so later stages can pick their
  // own chunk; sum fills from the bottom as the set moves down the pipe.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t           stage_q [STAGES];
  stage_t           stage_d [STAGES];
  logic [WIDTH-1:0] chunk_sum;
  logic [STAGES-1:0] chunk_cout;
  logic [WIDTH-1:0] b_first;
  logic             cin_first;
  logic             adv;

`ifdef ADDER_SUBTRACT_EN
  // Subtraction is a + ~b + 1; the inverted b travels down the pipe with its set.
  assign b_first   = bus.sub_in ? ~bus.b_in : bus.b_in;
  assign cin_first = bus.sub_in ? 1'b1      : bus.carry_in;
`else
  assign b_first   = bus.b_in;
  assign cin_first = bus.carry_in;
`endif

  assign adv           = ~stage_q[STAGES-1].valid | bus.ready_in;
  assign bus.ready_out = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [C-1:0] op_a;
    logic [C-1:0] op_b;
    logic         op_c;

    if (k == 0) begin : g_first
      assign op_a = bus.a_in[C-1:0];
      assign op_b = b_first[C-1:0];
      assign op_c = cin_first;
    end else begin : g_next
      assign op_a = stage_q[k-1].a[k*C +: C];
      assign op_b = stage_q[k-1].b[k*C +: C];
      assign op_c = stage_q[k-1].carry;
    end

    adder_chunk #(.WIDTH(C)) u_chunk (
      .a_in      (op_a),
      .b_in      (op_b),
      .carry_in  (op_c),
      .sum_out   (chunk_sum[k*C +: C]),
      .carry_out (chunk_cout[k])
    );
  end

  // Next value of every slot: stage 0 takes the fresh operand set, later stages
  // take the slot above them and drop their own chunk result into it.
  always_comb begin
    stage_d[0]            = '0;
    stage_d[0].valid      = bus.valid_in;
    stage_d[0].a          = bus.a_in;
    stage_d[0].b          = b_first;
    stage_d[0].carry      = chunk_cout[0];
    stage_d[0].sum[C-1:0] = chunk_sum[C-1:0];
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k]              = stage_q[k-1];
      stage_d[k].carry        = chunk_cout[k];
      stage_d[k].sum[k*C +: C] = chunk_sum[k*C +: C];
    end
  end

  // Global stall: on adv=0 every slot, bubbles included, keeps its contents.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign bus.sum_out   = stage_q[STAGES-1].sum;
  assign bus.carry_out = stage_q[STAGES-1].carry;
  assign bus.valid_out = stage_q[STAGES-1].valid;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
// Bench for pipelined_adder: an 8-bit/4-stage instance for directed tables,
// backpressure, reset and random traffic, and a 4-bit/2-stage instance for the
// exhaustive sweep. Each instance has a scoreboard queue fed from accepted
// operand sets using plain integer arithmetic.
module tb_pipelined_adder;

  localparam int W  = 8;
  localparam int S  = 4;
  localparam int W4 = 4;
  localparam int S4 = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W))  bus8 ();
  pipelined_adder_if #(.WIDTH(W4)) bus4 ();

  pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut8 (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus8.slave)
  );

  pipelined_adder #(.WIDTH(W4), .STAGES(S4)) u_dut4 (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus4.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vectors[$];

  logic [W:0]    exp8_q[$];
  int            acc8_q[$];
  bit            lat8_en = 1'b0;
  int            deliv8  = 0;
  bit            stall8  = 1'b0;
  logic [W+1:0]  prev8;

  logic [W4:0]   exp4_q[$];
  int            acc4_q[$];
  int            deliv4  = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact (W+1)-bit result of a + b + cin, or a - b as a + ~b + 1.
  function automatic logic [W:0] model8(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    int r;
    if (sub) r = int'(a) + int'(W'(~b)) + 1;
    else     r = int'(a) + int'(b) + int'(cin);
    return r[W:0];
  endfunction

  function automatic logic [W4:0] model4(input logic [W4-1:0] a, input logic [W4-1:0] b,
                                          input logic cin);
    int r;
    r = int'(a) + int'(b) + int'(cin);
    return r[W4:0];
  endfunction

  // Scoreboard for the 8-bit instance, sampled on the falling edge.
  always @(negedge clk) begin
    logic sub8;
`ifdef ADDER_SUBTRACT_EN
    sub8 = bus8.sub_in;
`else
    sub8 = 1'b0;
`endif
    if (!rst_n) begin
      exp8_q.delete();
      acc8_q.delete();
      stall8 = 1'b0;
    end else begin
      check_output("ready8", bus8.ready_out, !bus8.valid_out || bus8.ready_in);
      if (stall8)
        check_output("hold8", {bus8.valid_out, bus8.carry_out, bus8.sum_out}, prev8);
      if (exp8_q.size() == 0) begin
        check_output("idle8", bus8.valid_out, 1'b0);
      end else if (bus8.valid_out) begin
        check_output("result8", {bus8.carry_out, bus8.sum_out}, exp8_q[0]);
        if (bus8.ready_in) begin
          if (lat8_en) check_output("latency8", cyc - acc8_q[0], S);
          void'(exp8_q.pop_front());
          void'(acc8_q.pop_front());
          deliv8++;
        end
      end
      if (bus8.valid_in && bus8.ready_out) begin
        exp8_q.push_back(model8(bus8.a_in, bus8.b_in, bus8.carry_in, sub8));
        acc8_q.push_back(cyc);
      end
      stall8 = bus8.valid_out && !bus8.ready_in;
      prev8  = {bus8.valid_out, bus8.carry_out, bus8.sum_out};
    end
  end

  // Scoreboard for the 4-bit instance; its consumer is always ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp4_q.delete();
      acc4_q.delete();
    end else begin
      if (exp4_q.size() == 0) begin
        check_output("idle4", bus4.valid_out, 1'b0);
      end else if (bus4.valid_out) begin
        check_output("result4", {bus4.carry_out, bus4.sum_out}, exp4_q[0]);
        check_output("latency4", cyc - acc4_q[0], S4);
        void'(exp4_q.pop_front());
        void'(acc4_q.pop_front());
        deliv4++;
      end
      if (bus4.valid_in && bus4.ready_out) begin
        exp4_q.push_back(model4(bus4.a_in, bus4.b_in, bus4.carry_in));
        acc4_q.push_back(cyc);
      end
    end
  end

  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic sub, input logic vld, input logic rdy);
    bus8.a_in     = a;
    bus8.b_in     = b;
    bus8.carry_in = cin;
`ifdef ADDER_SUBTRACT_EN
    bus8.sub_in   = sub;
`else
    if (sub) $display("[TB] note: subtract vector skipped in add-only build");
`endif
    bus8.valid_in = vld;
    bus8.ready_in = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  n;
    bit  found;
    int  d0;

    bus8.a_in = '0; bus8.b_in = '0; bus8.carry_in = 1'b0;
    bus8.valid_in = 1'b1; bus8.ready_in = 1'b1;
    bus4.a_in = '0; bus4.b_in = '0; bus4.carry_in = 1'b0;
    bus4.valid_in = 1'b0; bus4.ready_in = 1'b1;
`ifdef ADDER_SUBTRACT_EN
    bus8.sub_in = 1'b0;
    bus4.sub_in = 1'b0;
`endif

    // Reset held with valid_in=1: outputs must stay cleared.
    bus8.a_in = 8'hFF; bus8.b_in = 8'h01;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rst_valid", bus8.valid_out, 1'b0);
      check_output("rst_sum",   bus8.sum_out,   '0);
      check_output("rst_carry", bus8.carry_out, 1'b0);
      check_output("rst_valid4", bus4.valid_out, 1'b0);
    end
    @(posedge clk);
    #1;
    lat8_en = 1'b1;
    rst_n   = 1'b1;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus8.valid_out) found = 1'b1;
      else n++;
    end
    check_output("first_seen", found, 1'b1);
    check_output("first_latency", n, S);
    @(posedge clk);
    #1;
    bus8.valid_in = 1'b0;
    idle_cycles(S + 3);
    check_output("drain_reset", exp8_q.size(), 0);

    // Directed vectors: boundaries of chunks and of the whole word.
    vectors.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vectors.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vectors.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vectors.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
    vectors.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vectors.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
    vectors.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0});
    vectors.push_back('{8'h03, 8'h01, 1'b0, 1'b0, 8'h04, 1'b0});
    vectors.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
`ifdef ADDER_SUBTRACT_EN
    vectors.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
    vectors.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1});
    vectors.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1});
`endif
    foreach (vectors[v]) begin
      apply_stimulus(vectors[v].a, vectors[v].b, vectors[v].cin, vectors[v].sub, 1'b1, 1'b1);
      bus8.valid_in = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (bus8.valid_out) begin
          found = 1'b1;
          check_output("tbl_sum",   bus8.sum_out,   vectors[v].sum);
          check_output("tbl_carry", bus8.carry_out, vectors[v].cout);
        end
      end
      check_output("tbl_seen", found, 1'b1);
      @(posedge clk);
      #1;
    end
`ifdef ADDER_SUBTRACT_EN
    bus8.sub_in = 1'b0;
`endif

    // Backpressure: four sets in, consumer stalls five cycles, then drains.
    lat8_en = 1'b0;
    d0 = deliv8;
    for (int i = 0; i < 4; i++)
      apply_stimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0);
    bus8.valid_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus8.valid_out) found = 1'b1;
    end
    check_output("bp_seen", found, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_output("bp_ready", bus8.ready_out, 1'b0);
      check_output("bp_valid", bus8.valid_out, 1'b1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus8.ready_in = 1'b1;
    idle_cycles(S + 4);
    check_output("bp_count", deliv8 - d0, 4);
    check_output("bp_drain", exp8_q.size(), 0);

    // Reset while two sets are in flight: neither may come out.
    lat8_en = 1'b1;
    d0 = deliv8;
    apply_stimulus(8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    apply_stimulus(8'h33, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1);
    bus8.valid_in = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus8.valid_out) found = 1'b1;
    end
    check_output("midrst_quiet", found, 1'b0);
    check_output("midrst_count", deliv8 - d0, 0);
    @(posedge clk);
    #1;

    // Random traffic with random bubbles and backpressure.
    lat8_en = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic sub;
`ifdef ADDER_SUBTRACT_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      apply_stimulus(W'($urandom), W'($urandom), 1'($urandom), sub,
                     ($urandom_range(9) < 7), ($urandom_range(9) < 7));
    end
`ifdef ADDER_SUBTRACT_EN
    bus8.sub_in = 1'b0;
`endif
    bus8.valid_in = 1'b0;
    bus8.ready_in = 1'b1;
    idle_cycles(S + 3);
    check_output("rand_drain", exp8_q.size(), 0);

    // Exhaustive 4-bit sweep, streamed back to back.
    d0 = deliv4;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] idx;
      idx = 9'(i);
      bus4.a_in     = idx[8:5];
      bus4.b_in     = idx[4:1];
      bus4.carry_in = idx[0];
      bus4.valid_in = 1'b1;
      @(posedge clk);
      #1;
    end
    bus4.valid_in = 1'b0;
    idle_cycles(S4 + 3);
    check_output("exh_count", deliv4 - d0, 512);
    check_output("exh_drain", exp4_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
